des_key_schedule: RTL and testbench

Sequential DES key-schedule generator feeding the PC-2 stage. Accepts a 64-bit key, applies PC-1 once, then steps the 28-bit C and D halves through the 16 round rotations (left for encryption, right for decryption). Each round's rotated halves are presented on `l_out`/`r_out` under a valid/ready handshake, so PC-2 and the round datapath can stall the schedule.

---
 rtl/des_key_schedule.sv | 159 +++++++++++++++
 tb/tb_des_key_schedule.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// DES key-schedule front end: PC-1 on load, then one C/D rotation per accepted round.
// Emits 16 rotated C/D pairs under valid/ready for a downstream PC-2 stage.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [64:1] key_in,
  output logic        ready,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [4:1]  round,
  output logic        last,
  output logic [28:1] r_out,
  output logic [28:1] l_out
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OUT  = 1'b1
  } state_e;

  localparam int PC1 [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  function automatic logic [56:1] pc1(input logic [64:1] key);
    logic [56:1] cd;
    cd = '0;
    for (int k = 1; k <= 56; k++) cd[k] = key[PC1[k]];
    return cd;
  endfunction

  // Index 1 is the FIPS leftmost bit, so a FIPS left rotate moves bit 1 to bit 28.
  function automatic logic [28:1] rotl1(input logic [28:1] v);
    return {v[1], v[28:2]};
  endfunction

  function automatic logic [28:1] rotl2(input logic [28:1] v);
    return {v[2:1], v[28:3]};
  endfunction

  function automatic logic [28:1] rotr1(input logic [28:1] v);
    return {v[27:1], v[28]};
  endfunction

  function automatic logic [28:1] rotr2(input logic [28:1] v);
    return {v[26:1], v[28:27]};
  endfunction

  state_e      r_state;
  state_e      w_next_state;
  logic [28:1] r_c;
  logic [28:1] r_d;
  logic [4:0]  r_round;
  logic        r_decrypt;
  logic        r_last;

  logic [56:1] w_cd0;
  logic [28:1] w_c0;
  logic [28:1] w_d0;
  logic        w_shift_one;
  logic [28:1] w_c_next;
  logic [28:1] w_d_next;

  assign w_cd0 = pc1(key_in);
  assign w_c0  = w_cd0[28:1];
  assign w_d0  = w_cd0[56:29];

  // Single-bit steps fall after rounds 1, 8 and 15 in both directions, since the
  // decrypt table is the encrypt table read backwards.
  assign w_shift_one = (r_round == 5'd1) || (r_round == 5'd8) || (r_round == 5'd15);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_c_next = r_c;
    w_d_next = r_d;
    if (r_decrypt) begin
      w_c_next = w_shift_one ? rotr1(r_c) : rotr2(r_c);
      w_d_next = w_shift_one ? rotr1(r_d) : rotr2(r_d);
    end else begin
      w_c_next = w_shift_one ? rotl1(r_c) : rotl2(r_c);
      w_d_next = w_shift_one ? rotl1(r_d) : rotl2(r_d);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_OUT;
      S_OUT:   if (sk_ready && (r_round == 5'd16)) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic: decoded from the state register only.
  always_comb begin
    ready    = 1'b0;
    sk_valid = 1'b0;
    case (r_state)
      S_IDLE:  ready    = 1'b1;
      S_OUT:   sk_valid = 1'b1;
      default: ready    = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c       <= '0;
      r_d       <= '0;
      r_round   <= '0;
      r_decrypt <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_c       <= decrypt ? w_c0 : rotl1(w_c0);
            r_d       <= decrypt ? w_d0 : rotl1(w_d0);
            r_decrypt <= decrypt;
            r_round   <= 5'd1;
            r_last    <= 1'b0;
          end
        end
        S_OUT: begin
          if (sk_ready) begin
            if (r_round != 5'd16) begin
              r_c     <= w_c_next;
              r_d     <= w_d_next;
              r_round <= r_round + 5'd1;
              r_last  <= (r_round == 5'd15);
            end else begin
              r_last  <= 1'b0;
            end
          end
        end
        default: r_last <= 1'b0;
      endcase
    end
  end

  // The port is four bits wide, so round 16 reads as 0; last/sk_valid tell it apart from reset.
  assign round = r_round[3:0];
  assign last  = r_last;
  assign r_out = r_c;
  assign l_out = r_d;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the FIPS 46-3 worked key 133457799BBCDFF1.
// Expected pairs come from hand-derived C0/D0 rotated by the cumulative shift count.
module tb_des_key_schedule;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [64:1] key_in;
  logic        ready;
  logic        sk_valid;
  logic        sk_ready;
  logic [4:1]  round;
  logic        last;
  logic [28:1] r_out;
  logic [28:1] l_out;

  int n_checks = 0;
  int n_errors = 0;

  des_key_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .decrypt  (decrypt),
    .key_in   (key_in),
    .ready    (ready),
    .sk_valid (sk_valid),
    .sk_ready (sk_ready),
    .round    (round),
    .last     (last),
    .r_out    (r_out),
    .l_out    (l_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] KEY_HEX = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_PAR = 64'h123556789ABDDEF0;
  localparam logic [63:0] KEY_ALT = 64'h0E329232EA6D0D73;

  // Constants below are written FIPS bit 1 first (leftmost).
  localparam logic [27:0] C0_M = 28'b1111000011001100101010101111;
  localparam logic [27:0] D0_M = 28'b0101010101100110011110001111;
  localparam logic [27:0] C1_M = 28'b1110000110011001010101011111;
  localparam logic [27:0] D1_M = 28'b1010101011001100111100011110;
  localparam logic [47:0] K1_M = 48'b000110110000001011101111111111000111000001110010;

  localparam int PC2 [1:48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic [62:0] obs;
  assign obs = {ready, sk_valid, last, round, r_out, l_out};

  function automatic logic [64:1] to_key(input logic [63:0] h);
    logic [64:1] r;
    for (int k = 1; k <= 64; k++) r[k] = h[64-k];
    return r;
  endfunction

  function automatic logic [28:1] fips28(input logic [27:0] m);
    logic [28:1] r;
    for (int k = 1; k <= 28; k++) r[k] = m[28-k];
    return r;
  endfunction

  // With FIPS bit 1 at the MSB, a FIPS left rotate is an ordinary left rotate.
  function automatic logic [27:0] rotl_m(input logic [27:0] x, input int n);
    if ((n % 28) == 0) return x;
    return (x << n) | (x >> (28 - n));
  endfunction

  function automatic int cum(input int x);
    int s = 0;
    for (int i = 1; i <= x; i++) s += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
    return s;
  endfunction

  // Expected {ready, sk_valid, last, round, C, D} for output position j.
  function automatic logic [62:0] exp_pair(input int j, input bit dec);
    int n;
    logic [3:0] r4;
    n  = dec ? cum(17 - j) : cum(j);
    r4 = 4'(j);
    return {1'b0, 1'b1, (j == 16), r4, fips28(rotl_m(C0_M, n)), fips28(rotl_m(D0_M, n))};
  endfunction

  function automatic logic [47:0] pc2_m(input logic [28:1] c, input logic [28:1] d);
    logic [56:1] cd;
    logic [47:0] k;
    cd = {d, c};
    for (int i = 1; i <= 48; i++) k[48-i] = cd[PC2[i]];
    return k;
  endfunction

  task automatic start_seq(input logic [63:0] h, input bit dec);
    key_in  = to_key(h);
    decrypt = dec;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    decrypt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    decrypt  = 1'b0;
    sk_ready = 1'b1;
    key_in   = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_checks++; if (sk_valid !== 1'b0) begin n_errors++; $display("FAIL reset_sk_valid: got %b expected 0", sk_valid); end
    n_checks++; if (last !== 1'b0) begin n_errors++; $display("FAIL reset_last: got %b expected 0", last); end
    n_checks++; if (round !== 4'd0) begin n_errors++; $display("FAIL reset_round: got %0d expected 0", round); end
    n_checks++; if (r_out !== 28'd0) begin n_errors++; $display("FAIL reset_r_out: got %h expected 0", r_out); end
    n_checks++; if (l_out !== 28'd0) begin n_errors++; $display("FAIL reset_l_out: got %h expected 0", l_out); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if ({ready, sk_valid} !== 2'b10) begin n_errors++; $display("FAIL idle_after_reset: got %b expected 10", {ready, sk_valid}); end
  endtask

  task automatic test_encrypt();
    start_seq(KEY_HEX, 1'b0);
    for (int j = 1; j <= 16; j++) begin
      n_checks++;
      if (obs !== exp_pair(j, 1'b0)) begin
        n_errors++; $display("FAIL enc_round%0d: got %h expected %h", j, obs, exp_pair(j, 1'b0));
      end
      if (j == 1) begin
        n_checks++; if (r_out !== fips28(C1_M)) begin n_errors++; $display("FAIL enc_c1: got %h expected %h", r_out, fips28(C1_M)); end
        n_checks++; if (l_out !== fips28(D1_M)) begin n_errors++; $display("FAIL enc_d1: got %h expected %h", l_out, fips28(D1_M)); end
        n_checks++; if (pc2_m(r_out, l_out) !== K1_M) begin n_errors++; $display("FAIL enc_k1: got %h expected %h", pc2_m(r_out, l_out), K1_M); end
      end
      if (j == 16) begin
        n_checks++; if ({r_out, l_out} !== {fips28(C0_M), fips28(D0_M)}) begin
          n_errors++; $display("FAIL enc_cd16: got %h expected %h", {r_out, l_out}, {fips28(C0_M), fips28(D0_M)});
        end
      end
      @(negedge clk);
    end
    n_checks++; if ({ready, sk_valid, last} !== 3'b100) begin n_errors++; $display("FAIL enc_done: got %b expected 100", {ready, sk_valid, last}); end
  endtask

  // Starts on the very cycle ready rises after the encrypt run.
  task automatic test_back_to_back_decrypt();
    start_seq(KEY_HEX, 1'b1);
    for (int j = 1; j <= 16; j++) begin
      n_checks++;
      if (obs !== exp_pair(j, 1'b1)) begin
        n_errors++; $display("FAIL dec_round%0d: got %h expected %h", j, obs, exp_pair(j, 1'b1));
      end
      if (j == 1) begin
        n_checks++; if ({r_out, l_out} !== {fips28(C0_M), fips28(D0_M)}) begin
          n_errors++; $display("FAIL dec_cd0: got %h expected %h", {r_out, l_out}, {fips28(C0_M), fips28(D0_M)});
        end
      end
      @(negedge clk);
    end
    n_checks++; if ({ready, sk_valid} !== 2'b10) begin n_errors++; $display("FAIL dec_done: got %b expected 10", {ready, sk_valid}); end
  endtask

  task automatic test_stall();
    start_seq(KEY_HEX, 1'b0);
    for (int j = 1; j <= 16; j++) begin
      n_checks++;
      if (obs !== exp_pair(j, 1'b0)) begin
        n_errors++; $display("FAIL stall_round%0d: got %h expected %h", j, obs, exp_pair(j, 1'b0));
      end
      if (j == 7) begin
        sk_ready = 1'b0;
        for (int s = 1; s <= 5; s++) begin
          @(negedge clk);
          n_checks++;
          if (obs !== exp_pair(7, 1'b0)) begin
            n_errors++; $display("FAIL stall_hold%0d: got %h expected %h", s, obs, exp_pair(7, 1'b0));
          end
        end
        sk_ready = 1'b1;
      end
      @(negedge clk);
    end
    n_checks++; if ({ready, sk_valid} !== 2'b10) begin n_errors++; $display("FAIL stall_done: got %b expected 10", {ready, sk_valid}); end
  endtask

  task automatic test_start_ignored();
    start_seq(KEY_HEX, 1'b0);
    for (int j = 1; j <= 16; j++) begin
      n_checks++;
      if (obs !== exp_pair(j, 1'b0)) begin
        n_errors++; $display("FAIL busy_start_round%0d: got %h expected %h", j, obs, exp_pair(j, 1'b0));
      end
      if (j == 4) begin
        key_in  = to_key(KEY_ALT);
        decrypt = 1'b1;
        start   = 1'b1;
      end else begin
        start   = 1'b0;
        decrypt = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++; if ({ready, sk_valid} !== 2'b10) begin n_errors++; $display("FAIL busy_start_done: got %b expected 10", {ready, sk_valid}); end
  endtask

  task automatic test_parity();
    start_seq(KEY_PAR, 1'b0);
    for (int j = 1; j <= 16; j++) begin
      n_checks++;
      if (obs !== exp_pair(j, 1'b0)) begin
        n_errors++; $display("FAIL parity_round%0d: got %h expected %h", j, obs, exp_pair(j, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    start_seq(KEY_HEX, 1'b0);
    for (int j = 1; j <= 10; j++) begin
      n_checks++;
      if (obs !== exp_pair(j, 1'b0)) begin
        n_errors++; $display("FAIL midrst_round%0d: got %h expected %h", j, obs, exp_pair(j, 1'b0));
      end
      if (j == 10) rst_n = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'd0, 56'd0}) begin
      n_errors++; $display("FAIL midrst_outputs: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 4'd0, 56'd0});
    end
    rst_n = 1'b1;
    start_seq(KEY_HEX, 1'b0);
    for (int j = 1; j <= 16; j++) begin
      n_checks++;
      if (obs !== exp_pair(j, 1'b0)) begin
        n_errors++; $display("FAIL midrst_restart%0d: got %h expected %h", j, obs, exp_pair(j, 1'b0));
      end
      @(negedge clk);
    end
    n_checks++; if ({ready, sk_valid} !== 2'b10) begin n_errors++; $display("FAIL midrst_done: got %b expected 10", {ready, sk_valid}); end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_back_to_back_decrypt();
    test_stall();
    test_start_ignored();
    test_parity();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
